// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Accepts one AES instruction plus a round count and issues one
//            control beat per round (inv/passthru/round index/key index) to
//            the AES round datapath under valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
  parameter int                W_INST         = 32,
  parameter int                W_CTRL         = 32,
  parameter int                RW             = 4,
  parameter int                MAX_ROUNDS     = 14,
  parameter logic [W_INST-1:0] OP_AESENC      = W_INST'(1),
  parameter logic [W_INST-1:0] OP_AESENCLAST  = W_INST'(2),
  parameter logic [W_INST-1:0] OP_AESDEC      = W_INST'(3),
  parameter logic [W_INST-1:0] OP_AESDECLAST  = W_INST'(4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_INST-1:0] inst,
  input  logic [RW-1:0]     n_rounds,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CTRL-1:0] inv_ctrl,
  output logic [W_CTRL-1:0] passthru_ctrl,
  output logic [RW-1:0]     round_idx,
  output logic [RW-1:0]     key_idx,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              illegal
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [RW-1:0] C_ONE      = RW'(1);
  localparam logic [RW-1:0] C_MAX_RNDS = RW'(MAX_ROUNDS);

  logic [0:0]    state_q, state_d;
  logic          inv_q, inv_d;
  logic          base_q, base_d;
  logic          illegal_q, illegal_d;
  logic [RW-1:0] n_q, n_d;
  logic [RW-1:0] k_q, k_d;

  logic          dec_legal;
  logic          dec_inv;
  logic          dec_base;
  logic [RW-1:0] dec_n;
  logic          beat_last;

  // Opcode decode: direction, base passthru, effective round count, legality
  always_comb begin
    dec_legal = 1'b0;
    dec_inv   = 1'b0;
    dec_base  = 1'b0;
    dec_n     = C_ONE;
    case (inst)
      OP_AESENC: begin
        dec_legal = (n_rounds <= C_MAX_RNDS);
        dec_n     = (n_rounds == '0) ? C_ONE : n_rounds;
      end
      OP_AESENCLAST: begin
        dec_legal = 1'b1;
        dec_base  = 1'b1;
      end
      OP_AESDEC: begin
        dec_legal = (n_rounds <= C_MAX_RNDS);
        dec_inv   = 1'b1;
        dec_n     = (n_rounds == '0) ? C_ONE : n_rounds;
      end
      OP_AESDECLAST: begin
        dec_legal = 1'b1;
        dec_inv   = 1'b1;
        dec_base  = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // The counter never exceeds n_q - 1, so it cannot wrap in RW bits
  assign beat_last = (k_q == (n_q - C_ONE));

  // State and block-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inv_q     <= 1'b0;
      base_q    <= 1'b0;
      illegal_q <= 1'b0;
      n_q       <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      inv_q     <= inv_d;
      base_q    <= base_d;
      illegal_q <= illegal_d;
      n_q       <= n_d;
      k_q       <= k_d;
    end
  end

  // Next-state: accept in IDLE, advance the beat counter on each handshake
  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    base_d    = base_q;
    n_d       = n_q;
    k_d       = k_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (dec_legal) begin
            state_d = S_ISSUE;
            inv_d   = dec_inv;
            base_d  = dec_base;
            n_d     = dec_n;
            k_d     = '0;
          end else begin
            // Rejected instructions are consumed and flagged for one cycle
            illegal_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (out_ready) begin
          if (beat_last) begin
            state_d = S_IDLE;
          end else begin
            k_d = k_q + C_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: beat fields are forced to zero whenever no beat is presented
  always_comb begin
    in_ready      = (state_q == S_IDLE);
    out_valid     = (state_q == S_ISSUE);
    busy          = (state_q == S_ISSUE);
    illegal       = illegal_q;
    inv_ctrl      = '0;
    passthru_ctrl = '0;
    round_idx     = '0;
    key_idx       = '0;
    first         = 1'b0;
    last          = 1'b0;
    if (state_q == S_ISSUE) begin
      inv_ctrl      = W_CTRL'(inv_q);
      passthru_ctrl = W_CTRL'(beat_last | base_q);
      round_idx     = k_q;
      key_idx       = inv_q ? (n_q - C_ONE - k_q) : (k_q + C_ONE);
      first         = (k_q == '0);
      last          = beat_last;
    end
  end

`ifdef DEBUG_DECODE
  // Trace each completed beat
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      $display("aes_round_sequencer: beat round=%0d key=%0d inv=%0d pass=%0d first=%0d last=%0d",
               round_idx, key_idx, inv_ctrl, passthru_ctrl, first, last);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Scoreboard bench for aes_round_sequencer: directed instructions
//            push expected beats, a monitor compares every completed beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

  localparam int W_INST = 32;
  localparam int W_CTRL = 32;
  localparam int RW     = 4;
  localparam int MAXR   = 14;
  localparam logic [31:0] OP_ENC  = 32'h1;
  localparam logic [31:0] OP_ENCL = 32'h2;
  localparam logic [31:0] OP_DEC  = 32'h3;
  localparam logic [31:0] OP_DECL = 32'h4;

  typedef struct packed {
    logic [W_CTRL-1:0] inv;
    logic [W_CTRL-1:0] pass;
    logic [RW-1:0]     ridx;
    logic [RW-1:0]     kidx;
    logic              first;
    logic              last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W_INST-1:0] inst;
  logic [RW-1:0]     n_rounds;
  logic              out_valid;
  logic              out_ready;
  logic [W_CTRL-1:0] inv_ctrl;
  logic [W_CTRL-1:0] passthru_ctrl;
  logic [RW-1:0]     round_idx;
  logic [RW-1:0]     key_idx;
  logic              first;
  logic              last;
  logic              busy;
  logic              illegal;

  beat_t act;
  assign act = {inv_ctrl, passthru_ctrl, round_idx, key_idx, first, last};

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    hs_cnt   = 0;
  logic  toggle_mode = 1'b0;

  aes_round_sequencer #(
    .W_INST(W_INST), .W_CTRL(W_CTRL), .RW(RW), .MAX_ROUNDS(MAXR),
    .OP_AESENC(OP_ENC), .OP_AESENCLAST(OP_ENCL),
    .OP_AESDEC(OP_DEC), .OP_AESDECLAST(OP_DECL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .n_rounds(n_rounds),
    .out_valid(out_valid), .out_ready(out_ready),
    .inv_ctrl(inv_ctrl), .passthru_ctrl(passthru_ctrl),
    .round_idx(round_idx), .key_idx(key_idx),
    .first(first), .last(last), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: expected beats of one legal instruction
  task automatic expect_block(input logic [31:0] op, input logic [3:0] n);
    int    nn;
    logic  iv;
    logic  base;
    beat_t b;
    iv = 1'b0; base = 1'b0; nn = 1;
    case (op)
      OP_ENC:  nn = (n == 0) ? 1 : int'(n);
      OP_ENCL: base = 1'b1;
      OP_DEC:  begin iv = 1'b1; nn = (n == 0) ? 1 : int'(n); end
      OP_DECL: begin iv = 1'b1; base = 1'b1; end
      default: nn = 0;
    endcase
    for (int k = 0; k < nn; k++) begin
      b.inv   = W_CTRL'(iv);
      b.pass  = W_CTRL'((k == nn - 1) ? 1'b1 : base);
      b.ridx  = k[3:0];
      b.kidx  = iv ? 4'(nn - 1 - k) : 4'(k + 1);
      b.first = (k == 0);
      b.last  = (k == nn - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [31:0] op, input logic [3:0] n);
    @(negedge clk);
    check("in_ready_before_send", in_ready, 1);
    inst = op; n_rounds = n; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(in_ready && exp_q.size() == 0) && cyc < max_cyc);
    if (!(in_ready && exp_q.size() == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle timeout: pending %0d in_ready %0b", exp_q.size(), in_ready);
    end
  endtask

  // out_ready driver: 1,0,0,1 pattern in toggle mode, otherwise held high
  initial begin : rdy_drv
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        out_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: compares completed beats and checks stability across stalls
  initial begin : mon
    beat_t snap;
    beat_t e;
    logic  stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled && rst_n) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_beat", act, snap);
      end
      stalled = 1'b0;
      if (rst_n && out_valid) begin
        if (out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none", act);
          end else begin
            e = exp_q.pop_front();
            check("beat", act, e);
          end
        end else begin
          stalled = 1'b1;
          snap    = act;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int    cyc;
    int    vcnt;
    beat_t hb;
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; n_rounds = '0;

    // Reset state
    #12;
    check("reset_outputs", {out_valid, inv_ctrl, passthru_ctrl, round_idx, key_idx,
                            first, last, busy, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    // AESENC, 10 rounds, out_ready high: beats on T+1..T+10, idle at T+11
    hs_cnt = 0;
    expect_block(OP_ENC, 4'd10);
    send(OP_ENC, 4'd10);
    wait_idle(100, cyc);
    check("enc10_idle_cycle", cyc, 11);
    check("enc10_handshakes", hs_cnt, 10);
    check("enc10_busy_clear", busy, 0);

    // AESDEC, 14 rounds, out_ready toggled 1,0,0,1
    hs_cnt = 0;
    toggle_mode = 1'b1;
    expect_block(OP_DEC, 4'd14);
    send(OP_DEC, 4'd14);
    wait_idle(200, cyc);
    check("dec14_handshakes", hs_cnt, 14);
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);

    // AESDECLAST, n_rounds ignored: single beat inv=1 pass=1 key=0
    hs_cnt = 0;
    hb = '{inv: 32'd1, pass: 32'd1, ridx: 4'd0, kidx: 4'd0, first: 1'b1, last: 1'b1};
    exp_q.push_back(hb);
    send(OP_DECL, 4'd9);
    wait_idle(50, cyc);
    check("declast_handshakes", hs_cnt, 1);

    // Unknown opcode: illegal pulse, nothing issued
    send(32'h0, 4'd4);
    @(negedge clk);
    check("illegal_op_pulse", illegal, 1);
    check("illegal_op_no_valid", out_valid, 0);
    check("illegal_op_in_ready", in_ready, 1);
    @(negedge clk);
    check("illegal_op_pulse_end", illegal, 0);

    // AESENC with n_rounds above MAX_ROUNDS
    send(OP_ENC, 4'd15);
    @(negedge clk);
    check("illegal_n_pulse", illegal, 1);
    check("illegal_n_no_valid", out_valid, 0);
    check("illegal_n_in_ready", in_ready, 1);
    @(negedge clk);
    check("illegal_n_pulse_end", illegal, 0);
    check("illegal_n_still_idle", out_valid, 0);

    // AESENC, n_rounds = 0: single beat pass=1 key=1
    hs_cnt = 0;
    hb = '{inv: 32'd0, pass: 32'd1, ridx: 4'd0, kidx: 4'd1, first: 1'b1, last: 1'b1};
    exp_q.push_back(hb);
    send(OP_ENC, 4'd0);
    wait_idle(50, cyc);
    check("enc0_handshakes", hs_cnt, 1);

    // Reset during beat 4 of a 12-round block
    expect_block(OP_ENC, 4'd12);
    send(OP_ENC, 4'd12);
    cyc = 0;
    while (!(out_valid && round_idx == 4'd4) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_beat4", {out_valid, round_idx}, {1'b1, 4'd4});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {out_valid, inv_ctrl, passthru_ctrl, round_idx, key_idx,
                                  first, last, busy, illegal}, 0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("post_reset_no_beats", vcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
